// File: rtl/vram_arbiter.sv
// Single-port text RAM arbiter: display fetch (fixed 2-cycle latency, never stalled),
// host write FIFO / host read on idle cycles, and a clear-screen fill engine.
module vram_arbiter #(
   parameter int COLS       = 100,
   parameter int ROWS       = 60,
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [6:0]        disp_col,
   input  logic [5:0]        disp_row,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [6:0]        host_wr_col,
   input  logic [5:0]        host_wr_row,
   input  logic [DATA_W-1:0] host_wr_data,
   input  logic              host_rd_valid,
   output logic              host_rd_ready,
   input  logic [6:0]        host_rd_col,
   input  logic [5:0]        host_rd_row,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              host_rd_data_valid,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_data,
   output logic              clr_busy,
   output logic              err_range,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS*ROWS-1);
   localparam logic [PTR_W:0]    FULL_XOR  = {1'b1, {PTR_W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   function automatic logic in_range(input logic [6:0] col, input logic [5:0] row);
      return (32'(col) < COLS) && (32'(row) < ROWS);
   endfunction

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] col, input logic [5:0] row);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]   clr_fill_q, clr_fill_d;
   logic                err_range_q, err_range_d;
   logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
   logic                disp_vld_p1_q, disp_vld_p1_d, disp_hit_p1_q, disp_hit_p1_d;
   logic                rd_vld_p1_q, rd_vld_p1_d, rd_hit_p1_q, rd_hit_p1_d;
   logic [DATA_W-1:0]   disp_data_q, disp_data_d, host_rd_data_q, host_rd_data_d;
   logic                disp_valid_q, disp_valid_d, host_rd_data_valid_q, host_rd_data_valid_d;

   logic fifo_empty, fifo_full, disp_hit, rd_hit, wr_hit;
   logic disp_go, pop, rd_go, clr_go, push, wr_acc;

   assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
   assign fifo_full     = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
   assign disp_hit      = in_range(disp_col, disp_row);
   assign rd_hit        = in_range(host_rd_col, host_rd_row);
   assign wr_hit        = in_range(host_wr_col, host_wr_row);
   // Grants are suppressed while reset is held so an aborted clear or queued write never lands.
   assign host_wr_ready = !reset && (state_q == S_IDLE) && !fifo_full;
   assign host_rd_ready = !reset && (state_q == S_IDLE) && fifo_empty && !disp_req;
   assign disp_go       = !reset && disp_req;
   assign pop           = !reset && !disp_req && (state_q != S_CLEAR) && !fifo_empty;
   assign rd_go         = host_rd_valid && host_rd_ready;
   assign clr_go        = !reset && !disp_req && (state_q == S_CLEAR);
   assign wr_acc        = host_wr_valid && host_wr_ready;
   assign push          = wr_acc && wr_hit;

   assign disp_data          = disp_data_q;
   assign disp_valid         = disp_valid_q;
   assign host_rd_data       = host_rd_data_q;
   assign host_rd_data_valid = host_rd_data_valid_q;
   assign clr_busy           = (state_q != S_IDLE);
   assign err_range          = err_range_q;

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (disp_go) begin
         ram_en   = disp_hit;
         ram_addr = cell_addr(disp_col, disp_row);
      end else if (pop) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
         ram_wdata = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
      end else if (rd_go) begin
         ram_en   = rd_hit;
         ram_addr = cell_addr(host_rd_col, host_rd_row);
      end else if (clr_go) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = clr_cnt_q;
         ram_wdata = clr_fill_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      clr_fill_d  = clr_fill_q;
      err_range_d = err_range_q | (wr_acc && !wr_hit);
      wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(push);
      rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(pop);
      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               state_d    = S_DRAIN;
               clr_fill_d = clr_data;
            end
         end
         S_DRAIN: begin
            if (fifo_empty) begin
               state_d   = S_CLEAR;
               clr_cnt_d = '0;
            end
         end
         S_CLEAR: begin
            if (clr_go) begin
               if (clr_cnt_q == LAST_CELL) state_d = S_IDLE;
               else clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Stage p1: RAM access issued this cycle; ram_rdata returns next cycle.
      disp_vld_p1_d = disp_go;
      disp_hit_p1_d = disp_hit;
      rd_vld_p1_d   = rd_go;
      rd_hit_p1_d   = rd_hit;

      // Stage p2: capture returned data (zero for out-of-range cells).
      disp_valid_d         = disp_vld_p1_q;
      disp_data_d          = disp_vld_p1_q ? (disp_hit_p1_q ? ram_rdata : '0) : disp_data_q;
      host_rd_data_valid_d = rd_vld_p1_q;
      host_rd_data_d       = rd_vld_p1_q ? (rd_hit_p1_q ? ram_rdata : '0) : host_rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q              <= S_IDLE;
         clr_cnt_q            <= '0;
         err_range_q          <= 1'b0;
         wr_ptr_q             <= '0;
         rd_ptr_q             <= '0;
         disp_vld_p1_q        <= 1'b0;
         rd_vld_p1_q          <= 1'b0;
         disp_valid_q         <= 1'b0;
         disp_data_q          <= '0;
         host_rd_data_valid_q <= 1'b0;
         host_rd_data_q       <= '0;
      end else begin
         state_q              <= state_d;
         clr_cnt_q            <= clr_cnt_d;
         err_range_q          <= err_range_d;
         wr_ptr_q             <= wr_ptr_d;
         rd_ptr_q             <= rd_ptr_d;
         disp_vld_p1_q        <= disp_vld_p1_d;
         rd_vld_p1_q          <= rd_vld_p1_d;
         disp_valid_q         <= disp_valid_d;
         disp_data_q          <= disp_data_d;
         host_rd_data_valid_q <= host_rd_data_valid_d;
         host_rd_data_q       <= host_rd_data_d;
      end
      clr_fill_q    <= clr_fill_d;
      disp_hit_p1_q <= disp_hit_p1_d;
      rd_hit_p1_q   <= rd_hit_p1_d;
      if (push) begin
         fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= cell_addr(host_wr_col, host_wr_row);
         fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= host_wr_data;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM attached.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req;
   logic [6:0]  disp_col;
   logic [5:0]  disp_row;
   logic [15:0] disp_data;
   logic        disp_valid;
   logic        host_wr_valid, host_wr_ready;
   logic [6:0]  host_wr_col;
   logic [5:0]  host_wr_row;
   logic [15:0] host_wr_data;
   logic        host_rd_valid, host_rd_ready;
   logic [6:0]  host_rd_col;
   logic [5:0]  host_rd_row;
   logic [15:0] host_rd_data;
   logic        host_rd_data_valid;
   logic        clr_start;
   logic [15:0] clr_data;
   logic        clr_busy, err_range;
   logic        ram_en, ram_we;
   logic [12:0] ram_addr;
   logic [15:0] ram_wdata, ram_rdata;

   logic        pre_we;
   logic [12:0] pre_addr;
   logic [15:0] pre_data;
   logic [15:0] mem [0:5999];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_col(disp_col), .disp_row(disp_row),
      .disp_data(disp_data), .disp_valid(disp_valid),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_col(host_wr_col), .host_wr_row(host_wr_row), .host_wr_data(host_wr_data),
      .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
      .host_rd_col(host_rd_col), .host_rd_row(host_rd_row),
      .host_rd_data(host_rd_data), .host_rd_data_valid(host_rd_data_valid),
      .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy),
      .err_range(err_range),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [12:0] a, input logic [15:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   initial begin
      int busy, dcnt, bad;
      logic seen;
      reset = 1'b1; disp_req = 1'b0; disp_col = '0; disp_row = '0;
      host_wr_valid = 1'b0; host_wr_col = '0; host_wr_row = '0; host_wr_data = '0;
      host_rd_valid = 1'b0; host_rd_col = '0; host_rd_row = '0;
      clr_start = 1'b0; clr_data = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      ram_rdata = '0;
      tick();
      preload(13'd205, 16'h1241);
      tick();
      reset = 1'b0;
      #1;
      chk("rst_disp_valid", 32'(disp_valid), 32'(0));
      chk("rst_disp_data",  32'(disp_data), 32'(0));
      chk("rst_rd_dvalid",  32'(host_rd_data_valid), 32'(0));
      chk("rst_clr_busy",   32'(clr_busy), 32'(0));
      chk("rst_err_range",  32'(err_range), 32'(0));
      chk("rst_wr_ready",   32'(host_wr_ready), 32'(1));
      chk("rst_rd_ready",   32'(host_rd_ready), 32'(1));
      chk("rst_ram_en",     32'(ram_en), 32'(0));
      tick();

      // display fetch at (5,2)
      disp_req = 1'b1; disp_col = 7'd5; disp_row = 6'd2;
      #1;
      chk("disp_ram_en",   32'(ram_en), 32'(1));
      chk("disp_ram_we",   32'(ram_we), 32'(0));
      chk("disp_ram_addr", 32'(ram_addr), 32'(205));
      chk("disp_rd_ready", 32'(host_rd_ready), 32'(0));
      tick();
      disp_req = 1'b0;
      chk("disp_n1_valid", 32'(disp_valid), 32'(0));
      tick();
      chk("disp_n2_valid", 32'(disp_valid), 32'(1));
      chk("disp_n2_data",  32'(disp_data), 32'(16'h1241));
      tick();
      chk("disp_n3_valid", 32'(disp_valid), 32'(0));

      // write (99,59) then read it back
      host_wr_valid = 1'b1; host_wr_col = 7'd99; host_wr_row = 6'd59; host_wr_data = 16'hBEEF;
      #1;
      chk("wr_ready", 32'(host_wr_ready), 32'(1));
      chk("wr_no_ram_same_cycle", 32'(ram_en), 32'(0));
      tick();
      host_wr_valid = 1'b0;
      host_rd_valid = 1'b1; host_rd_col = 7'd99; host_rd_row = 6'd59;
      #1;
      chk("rd_held_off", 32'(host_rd_ready), 32'(0));
      chk("wr_ram_we",   32'(ram_we), 32'(1));
      chk("wr_ram_addr", 32'(ram_addr), 32'(5999));
      chk("wr_ram_data", 32'(ram_wdata), 32'(16'hBEEF));
      tick();
      chk("rd_ready_now", 32'(host_rd_ready), 32'(1));
      chk("rd_ram_rd",    32'({ram_en, ram_we}), 32'(2'b10));
      chk("rd_ram_addr",  32'(ram_addr), 32'(5999));
      tick();
      host_rd_valid = 1'b0;
      chk("rd_n1_dvalid", 32'(host_rd_data_valid), 32'(0));
      tick();
      chk("rd_n2_dvalid", 32'(host_rd_data_valid), 32'(1));
      chk("rd_n2_data",   32'(host_rd_data), 32'(16'hBEEF));

      // contention: display blocks draining until the FIFO is full
      for (int i = 0; i < 5; i++) begin
         disp_req = 1'b1; disp_col = 7'd5; disp_row = 6'd2;
         host_wr_valid = 1'b1; host_wr_col = 7'(10 + i); host_wr_row = 6'd1;
         host_wr_data = 16'hA000 + 16'(i);
         #1;
         chk($sformatf("cont_wr_ready_%0d", i), 32'(host_wr_ready), 32'(i < 4));
         chk($sformatf("cont_disp_valid_%0d", i), 32'(disp_valid), 32'(i >= 2));
         if (i >= 2) chk($sformatf("cont_disp_data_%0d", i), 32'(disp_data), 32'(16'h1241));
         tick();
      end
      host_wr_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         disp_req = (i == 4);
         #1;
         chk($sformatf("drain_disp_valid_%0d", i), 32'(disp_valid), 32'((i < 2) || (i == 6)));
         if (i < 4) chk($sformatf("drain_we_%0d", i), 32'(ram_we), 32'(1));
         tick();
      end
      disp_req = 1'b0;
      for (int i = 0; i < 4; i++)
         chk($sformatf("cont_mem_%0d", i), 32'(mem[110 + i]), 32'(16'hA000 + 16'(i)));

      // out-of-range write, display and read
      host_wr_valid = 1'b1; host_wr_col = 7'd100; host_wr_row = 6'd0; host_wr_data = 16'h9999;
      #1;
      chk("oor_wr_ready", 32'(host_wr_ready), 32'(1));
      tick();
      host_wr_valid = 1'b0;
      #1;
      chk("oor_err_range", 32'(err_range), 32'(1));
      chk("oor_not_queued", 32'(ram_en), 32'(0));
      tick();
      disp_req = 1'b1; disp_col = 7'd0; disp_row = 6'd60;
      #1;
      chk("oor_disp_no_ram", 32'(ram_en), 32'(0));
      tick();
      disp_req = 1'b0;
      tick();
      chk("oor_disp_valid", 32'(disp_valid), 32'(1));
      chk("oor_disp_data",  32'(disp_data), 32'(0));
      host_rd_valid = 1'b1; host_rd_col = 7'd0; host_rd_row = 6'd60;
      #1;
      chk("oor_rd_ready",  32'(host_rd_ready), 32'(1));
      chk("oor_rd_no_ram", 32'(ram_en), 32'(0));
      tick();
      host_rd_valid = 1'b0;
      tick();
      chk("oor_rd_dvalid", 32'(host_rd_data_valid), 32'(1));
      chk("oor_rd_data",   32'(host_rd_data), 32'(0));

      // full clear under periodic display strobes; a second start is ignored
      clr_start = 1'b1; clr_data = 16'h0720;
      #1;
      chk("clr_idle_before", 32'(clr_busy), 32'(0));
      tick();
      clr_start = 1'b0; clr_data = '0;
      busy = 0; dcnt = 0; seen = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         disp_req = (k % 4 == 1); disp_col = 7'd5; disp_row = 6'd2;
         clr_start = (k == 100); clr_data = (k == 100) ? 16'h1111 : 16'h0;
         #1;
         if (!clr_busy) break;
         busy++;
         if (disp_req && busy > 1) dcnt++;
         if (host_wr_ready || host_rd_ready) seen = 1'b1;
         tick();
      end
      disp_req = 1'b0; clr_start = 1'b0;
      chk("clr_duration", 32'(busy), 32'(6001 + dcnt));
      chk("clr_host_ready_low", 32'(seen), 32'(0));
      bad = 0;
      for (int a = 0; a < 6000; a++) if (mem[a] !== 16'h0720) bad++;
      chk("clr_cells_bad", 32'(bad), 32'(0));
      chk("err_sticky", 32'(err_range), 32'(1));
      tick();

      // reset with a queued write and an in-flight display fetch
      disp_req = 1'b1; disp_col = 7'd5; disp_row = 6'd2;
      host_wr_valid = 1'b1; host_wr_col = 7'd20; host_wr_row = 6'd3; host_wr_data = 16'h5555;
      #1;
      chk("rstq_wr_ready", 32'(host_wr_ready), 32'(1));
      tick();
      disp_req = 1'b0; host_wr_valid = 1'b0; reset = 1'b1;
      #1;
      chk("rstq_no_ram_in_reset", 32'(ram_en), 32'(0));
      tick();
      reset = 1'b0;
      #1;
      chk("rstq_disp_cancel", 32'(disp_valid), 32'(0));
      chk("rstq_fifo_empty",  32'(host_rd_ready), 32'(1));
      chk("rstq_err_cleared", 32'(err_range), 32'(0));
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (ram_en) seen = 1'b1;
         tick();
      end
      chk("rstq_no_ram_after", 32'(seen), 32'(0));
      chk("rstq_mem_untouched", 32'(mem[320]), 32'(16'h0720));

      // reset in the middle of a clear
      clr_start = 1'b1; clr_data = 16'h3333;
      tick();
      clr_start = 1'b0; clr_data = '0;
      for (int i = 0; i < 20; i++) tick();
      chk("rstc_busy_before", 32'(clr_busy), 32'(1));
      reset = 1'b1;
      #1;
      chk("rstc_no_we_in_reset", 32'(ram_we), 32'(0));
      tick();
      reset = 1'b0;
      #1;
      chk("rstc_busy_after", 32'(clr_busy), 32'(0));
      chk("rstc_wr_ready",   32'(host_wr_ready), 32'(1));
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (ram_we) seen = 1'b1;
         tick();
      end
      chk("rstc_no_writes", 32'(seen), 32'(0));
      chk("rstc_mem_head",  32'(mem[5]), 32'(16'h3333));
      chk("rstc_mem_tail",  32'(mem[100]), 32'(16'h0720));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
